w_stage: RTL
============

W_STAGE -- requirements
Module: w_stage

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64: width of the retired-instruction counter.
REQ-002 SHALL have parameter NUM_REGS, default 32: number of architectural registers; the address width is log2(NUM_REGS).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  when high, holds the stage register and suppresses writeback.
REQ-006 valid_in  input  1  the incoming M-stage result is a real instruction.
REQ-007 data_in  input  N_BITS  result data from the M stage output mux.
REQ-008 rf_wb_ctrl_pkt_in  input  rf_wb_ctrl_t  writeback control from the M stage (fields en, addr).
REQ-009 rs1_addr, rs2_addr  input  5 each  D-stage register read addresses.
REQ-010 rs1_data, rs2_data  output  N_BITS each  register read data.
REQ-011 wb_valid, wb_addr, wb_data  output  1/5/N_BITS  current writeback, exported for forwarding.
REQ-012 instret  output  INSTRET_W  count of retired instructions.

Function
REQ-013 The stage register SHALL capture valid_in, data_in and rf_wb_ctrl_pkt_in on each rising clk edge where stall=0, and SHALL hold its value while stall=1.
REQ-014 wb_valid SHALL equal registered valid AND registered ctrl.en AND (registered addr != 0) AND stall=0.
REQ-015 When wb_valid=1, the register file SHALL write wb_data to entry wb_addr at the next rising edge; each held instruction writes exactly once, in the first non-stalled cycle.
REQ-016 Register reads SHALL be combinational; an address of 0 SHALL always read 0; entry 0 SHALL never be written.
REQ-017 instret SHALL increment by 1 in each cycle where registered valid=1 and stall=0, independent of ctrl.en, and SHALL wrap modulo 2^INSTRET_W.
REQ-018 Two identical read addresses SHALL return identical data; simultaneous read and write of the same address is governed by REQ-022/023.
REQ-019 Total latency SHALL be 1 cycle: an M-stage result is visible on wb_* in the cycle after capture, and it is architecturally readable from the cycle after that.

Reset
REQ-020 While rst_n=0, the stage register (valid, data, ctrl), all register-file entries and instret SHALL clear to 0 asynchronously; as a result wb_valid=0 and rs*_data=0.
REQ-021 Reset asserted mid-stall SHALL discard the held instruction; it SHALL NOT be written and SHALL NOT be counted.

Configuration
REQ-022 With W_STAGE_RF_BYPASS_EN defined, a read whose address equals wb_addr while wb_valid=1 SHALL return wb_data in the same cycle (write-before-read).
REQ-023 Without W_STAGE_RF_BYPASS_EN, that read SHALL return the old entry value; the new value is visible in the next cycle.

Structure
REQ-024 rf_wb_ctrl_t (en:1, addr:5), N_BITS and the register-address width SHALL live in core_types_pkg.
REQ-025 The register file SHALL be a sub-module named regfile_2r1w, with 2 asynchronous read ports and 1 synchronous write port, and zero-hardwired entry 0; the stage register SHALL use dl_reg_en_rst with en=~stall.

Verification
REQ-026 valid=1, en=1, addr=5, data=0xDEADBEEF, stall=0 -> next cycle wb_valid=1, wb_addr=5; one cycle later rs1_addr=5 reads 0xDEADBEEF; instret=1.
REQ-027 valid=1, en=1, addr=0, data=0x1234 -> wb_valid=0; rs1_addr=0 reads 0; instret increments to 1.
REQ-028 Capture a write to x7 (=0x55), then hold stall=1 for 3 cycles -> no write and instret unchanged during the stall; exactly one write and +1 instret on the first cycle with stall=0.
REQ-029 x3=0x11, then a write of 0x22 to x3 with rs2_addr=3 in the wb cycle -> rs2_data=0x22 with W_STAGE_RF_BYPASS_EN, 0x11 without; both read 0x22 the next cycle.
REQ-030 Preload instret to 2^INSTRET_W-1 (force, or INSTRET_W=4 build) and retire one instruction -> instret=0; rst_n pulse mid-stall -> all outputs 0 and no write of the held instruction.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types: datapath width, register-address width and the
// writeback control packet passed from the M stage to the W stage.
package core_types_pkg;

    localparam int unsigned N_BITS     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
    } rf_wb_ctrl_t;

endpackage

// File: rtl/dl_reg_en_rst.sv
// Generic enabled register with asynchronous active-low clear.
module dl_reg_en_rst #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is hardwired to zero: never written, always reads 0.
module regfile_2r1w #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Clear all entries on reset; write any entry except 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational reads; address 0 is forced to zero.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
    end

endmodule

// File: rtl/w_stage.sv
// Writeback stage: stage register, register-file write, retired-instruction
// counter and register read ports for the D stage.
// Optional macro W_STAGE_RF_BYPASS_EN: a read that hits the current
// writeback address returns wb_data in the same cycle.
module w_stage
    import core_types_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 valid_in,
    input  logic [N_BITS-1:0]    data_in,
    input  rf_wb_ctrl_t          rf_wb_ctrl_pkt_in,
    input  reg_addr_t            rs1_addr,
    input  reg_addr_t            rs2_addr,
    output logic [N_BITS-1:0]    rs1_data,
    output logic [N_BITS-1:0]    rs2_data,
    output logic                 wb_valid,
    output reg_addr_t            wb_addr,
    output logic [N_BITS-1:0]    wb_data,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned STAGE_W = 1 + $bits(rf_wb_ctrl_t) + N_BITS;

    logic [STAGE_W-1:0] stage_d, stage_q;
    logic               valid_q;
    rf_wb_ctrl_t        ctrl_q;
    logic [N_BITS-1:0]  data_q;
    logic [N_BITS-1:0]  rf_rs1_data, rf_rs2_data;
    logic [INSTRET_W-1:0] instret_q;

    assign stage_d = {valid_in, rf_wb_ctrl_pkt_in, data_in};
    assign {valid_q, ctrl_q, data_q} = stage_q;

    dl_reg_en_rst #(
        .WIDTH (STAGE_W)
    ) u_stage_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .d     (stage_d),
        .q     (stage_q)
    );

    // Writeback fires only in a non-stalled cycle, so a held instruction
    // writes once: the unstall edge also replaces the stage contents.
    always_comb begin
        wb_valid = valid_q & ctrl_q.en & (ctrl_q.addr != '0) & ~stall;
        wb_addr  = ctrl_q.addr;
        wb_data  = data_q;
    end

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (N_BITS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_valid),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .rdata1 (rf_rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rf_rs2_data)
    );

    // Count every valid instruction leaving the stage, written or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (valid_q && !stall) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret = instret_q;

    // Read data, optionally forwarding the in-flight writeback.
    always_comb begin
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
`ifdef W_STAGE_RF_BYPASS_EN
        // wb_valid implies wb_addr != 0, so x0 still reads zero.
        if (wb_valid && (rs1_addr == wb_addr)) rs1_data = wb_data;
        if (wb_valid && (rs2_addr == wb_addr)) rs2_data = wb_data;
`endif
    end

endmodule
